// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes a seeded address pattern to SDRAM, reads it back and reports errors
module sdram_pattern_tester #(
    parameter logic [23:0] LAST_ADDR  = 24'hFFFFFF,
    parameter int          RD_TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_seed,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err_count,
    output logic [23:0] o_first_err_addr,
    output logic        o_timeout_seen,
    output logic        o_sdram_req,
    input  logic        i_sdram_ack,
    output logic [23:0] o_sdram_addr,
    output logic        o_sdram_rh_wl,
    output logic [15:0] o_sdram_data_w,
    input  logic [15:0] i_sdram_data_r,
    input  logic        i_sdram_data_r_en
);
    localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_NEXT, S_RD_REQ, S_RD_WAIT, S_RD_NEXT, S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_seed, w_seed_nxt;
    logic [23:0]   r_addr, w_addr_nxt;
    logic [15:0]   r_data_w, w_data_w_nxt;
    logic          r_req, w_req_nxt;
    logic          r_rh_wl, w_rh_wl_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_pass, w_pass_nxt;
    logic [15:0]   r_err_count, w_err_nxt;
    logic [23:0]   r_first_err_addr, w_first_nxt;
    logic          r_timeout_seen, w_to_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          w_accept, w_last, w_cmp, w_timeout, w_log_err;

    function automatic logic [15:0] f_pattern(input logic [23:0] a, input logic [15:0] s);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ s;
    endfunction

    assign w_accept  = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last    = r_addr == LAST_ADDR;
    assign w_cmp     = i_sdram_data_r_en && ((r_state == S_RD_REQ && i_sdram_ack) || r_state == S_RD_WAIT);
    assign w_timeout = r_state == S_RD_WAIT && !i_sdram_data_r_en && r_timer == TIMER_MAX;
    assign w_log_err = (w_cmp && i_sdram_data_r != f_pattern(r_addr, r_seed)) || w_timeout;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic: write sweep, then read sweep, then hold results
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = w_accept ? S_WR_REQ : r_state;
            S_WR_REQ:       w_state_nxt = i_sdram_ack ? S_WR_NEXT : S_WR_REQ;
            S_WR_NEXT:      w_state_nxt = w_last ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:       w_state_nxt = !i_sdram_ack ? S_RD_REQ : (i_sdram_data_r_en ? S_RD_NEXT : S_RD_WAIT);
            S_RD_WAIT:      w_state_nxt = (i_sdram_data_r_en || w_timeout) ? S_RD_NEXT : S_RD_WAIT;
            S_RD_NEXT:      w_state_nxt = w_last ? S_DONE : S_RD_REQ;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // next values of datapath and outputs, derived from the next state so every output is a flop
    always_comb begin
        w_seed_nxt   = w_accept ? i_seed : r_seed;
        w_addr_nxt   = w_accept ? '0
                     : (r_state == S_WR_NEXT) ? (w_last ? '0 : r_addr + 24'd1)
                     : (r_state == S_RD_NEXT && !w_last) ? r_addr + 24'd1
                     : r_addr;
        w_timer_nxt  = (r_state == S_RD_WAIT) ? r_timer + TW'(1) : '0;
        w_err_nxt    = w_accept ? '0 : (w_log_err && r_err_count != 16'hFFFF) ? r_err_count + 16'd1 : r_err_count;
        w_first_nxt  = w_accept ? '0 : (w_log_err && r_err_count == '0) ? r_addr : r_first_err_addr;
        w_to_nxt     = w_accept ? 1'b0 : (w_timeout || r_timeout_seen);
        w_req_nxt    = w_state_nxt == S_WR_REQ || w_state_nxt == S_RD_REQ;
        w_rh_wl_nxt  = (w_state_nxt == S_WR_REQ) ? 1'b0 : (w_state_nxt == S_RD_REQ) ? 1'b1 : r_rh_wl;
        w_data_w_nxt = (w_state_nxt == S_WR_REQ) ? f_pattern(w_addr_nxt, w_seed_nxt) : r_data_w;
        w_busy_nxt   = !(w_state_nxt == S_IDLE || w_state_nxt == S_DONE);
        w_done_nxt   = w_state_nxt == S_DONE;
        w_pass_nxt   = w_done_nxt && w_err_nxt == '0;
    end

    // datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seed           <= '0;
            r_addr           <= '0;
            r_data_w         <= '0;
            r_req            <= 1'b0;
            r_rh_wl          <= 1'b1;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_timeout_seen   <= 1'b0;
            r_timer          <= '0;
        end else begin
            r_seed           <= w_seed_nxt;
            r_addr           <= w_addr_nxt;
            r_data_w         <= w_data_w_nxt;
            r_req            <= w_req_nxt;
            r_rh_wl          <= w_rh_wl_nxt;
            r_busy           <= w_busy_nxt;
            r_done           <= w_done_nxt;
            r_pass           <= w_pass_nxt;
            r_err_count      <= w_err_nxt;
            r_first_err_addr <= w_first_nxt;
            r_timeout_seen   <= w_to_nxt;
            r_timer          <= w_timer_nxt;
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_timeout_seen   = r_timeout_seen;
    assign o_sdram_req      = r_req;
    assign o_sdram_addr     = r_addr;
    assign o_sdram_rh_wl    = r_rh_wl;
    assign o_sdram_data_w   = r_data_w;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: randomized memory-stub bench for sdram_pattern_tester
module tb_sdram_pattern_tester;
    localparam int LAST = 15;

    logic        clk = 1'b0;
    logic        rst, start, ack, den, busy, done, pass, to_seen, req, rh_wl;
    logic [15:0] seed, err_cnt, data_w, data_r;
    logic [23:0] first_err, addr;

    int          n_chk = 0;
    int          n_err = 0;
    int          ack_min, ack_max, rd_mode, flip_addr, to_addr, hold_addr;
    bit          spur;
    logic [15:0] flip_mask, run_seed;
    int          wr_n, rd_n;
    logic [15:0] mem [0:LAST];

    always #5 clk = ~clk;

    sdram_pattern_tester #(.LAST_ADDR(24'd15), .RD_TIMEOUT(10)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_seed(seed),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err_cnt),
        .o_first_err_addr(first_err), .o_timeout_seen(to_seen),
        .o_sdram_req(req), .i_sdram_ack(ack), .o_sdram_addr(addr),
        .o_sdram_rh_wl(rh_wl), .o_sdram_data_w(data_w),
        .i_sdram_data_r(data_r), .i_sdram_data_r_en(den)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [23:0] a, input logic [15:0] s);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ s;
    endfunction

    // memory stub: acks after a chosen delay, stores writes, returns reads with optional faults
    initial begin
        int cnt, dly, rd_cnt, d;
        logic [15:0] rd_val, v, h_dat;
        logic [23:0] h_addr;
        logic        h_rw;
        cnt = 0; dly = 1; rd_cnt = 0; rd_val = 0;
        h_addr = 0; h_rw = 0; h_dat = 0;
        ack = 0; den = 0; data_r = 0;
        forever begin
            @(negedge clk);
            ack = 0;
            den = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    den = 1;
                    data_r = rd_val;
                end
            end else if (spur && !rh_wl && $urandom_range(3, 0) == 0) begin
                den = 1;
                data_r = 16'($urandom);
            end
            if (!req) cnt = 0;
            else begin
                if (cnt == 0) begin
                    dly = (hold_addr >= 0 && !rh_wl && addr == 24'(hold_addr)) ? 50 : int'($urandom_range(ack_max, ack_min));
                    h_addr = addr; h_rw = rh_wl; h_dat = data_w;
                end else if (dly == 50) begin
                    check("hold_addr", addr, h_addr);
                    check("hold_rh_wl", rh_wl, h_rw);
                    check("hold_data_w", data_w, h_dat);
                end
                cnt++;
                if (cnt == dly) begin
                    ack = 1;
                    if (!rh_wl) begin
                        check("wr_addr", addr, wr_n);
                        check("wr_data", data_w, pat(addr, run_seed));
                        mem[addr[3:0]] = data_w;
                        wr_n++;
                    end else begin
                        check("rd_addr", addr, rd_n);
                        rd_n++;
                        if (addr != 24'(to_addr)) begin
                            v = mem[addr[3:0]] ^ ((addr == 24'(flip_addr)) ? flip_mask : 16'h0);
                            d = (rd_mode < 0) ? int'($urandom_range(4, 0)) : rd_mode;
                            if (d == 0) begin
                                den = 1;
                                data_r = v;
                            end else begin
                                rd_cnt = d;
                                rd_val = v;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] s);
        seed = s;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(input logic [15:0] s, input int amin, input int amax, input int rdm,
                       input int fa, input logic [15:0] fm, input int ta, input int ha, input bit sp);
        int k, exp_err, exp_first;
        ack_min = amin; ack_max = amax; rd_mode = rdm; flip_addr = fa; flip_mask = fm;
        to_addr = ta; hold_addr = ha; spur = sp; wr_n = 0; rd_n = 0; run_seed = s;
        pulse_start(s);
        check("busy_rise", busy, 1);
        check("done_clr", done, 0);
        if (ha >= 0) begin
            k = 0;
            while (!(req && !rh_wl && addr == 24'(ha)) && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("hold_reached", k < 500, 1);
            repeat (20) @(negedge clk);
            pulse_start(~s);
        end
        k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("done", done, 1);
        exp_err = 0;
        exp_first = 0;
        for (int a = 0; a <= LAST; a++)
            if (a == fa || a == ta) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        check("busy_end", busy, 0);
        check("req_end", req, 0);
        check("pass", pass, exp_err == 0);
        check("err_count", err_cnt, exp_err);
        check("first_err", first_err, exp_first);
        check("timeout_seen", to_seen, ta >= 0);
        check("writes", wr_n, LAST + 1);
        check("reads", rd_n, LAST + 1);
    endtask

    initial begin
        int k, fa, ta;
        rst = 1; start = 0; seed = 0;
        ack_min = 2; ack_max = 2; rd_mode = 3; flip_addr = -1; flip_mask = 0;
        to_addr = -1; hold_addr = -1; spur = 0; wr_n = 0; rd_n = 0; run_seed = 0;
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_rh_wl", rh_wl, 1);
        check("rst_addr", addr, 0);
        check("rst_data_w", data_w, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_first", first_err, 0);
        check("rst_timeout", to_seen, 0);
        rst = 0;
        @(negedge clk);
        run(16'h0000, 2, 2, 3, -1, 16'h0, -1, -1, 0);
        run(16'hA5A5, 2, 2, 3, 7, 16'h0001, -1, -1, 0);
        run(16'h3C3C, 2, 2, 0, -1, 16'h0, -1, -1, 0);
        run(16'h1111, 2, 2, 3, -1, 16'h0, 3, -1, 0);
        run(16'h5A5A, 2, 2, 3, -1, 16'h0, -1, 5, 0);
        ack_min = 1; ack_max = 3; rd_mode = -1; flip_addr = -1; to_addr = -1; hold_addr = -1; spur = 0;
        wr_n = 0; rd_n = 0; run_seed = 16'h1234;
        pulse_start(16'h1234);
        k = 0;
        while (!(req && rh_wl) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_read", req && rh_wl, 1);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("mid_rst_req", req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_first", first_err, 0);
        check("mid_rst_timeout", to_seen, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_rh_wl", rh_wl, 1);
        rst = 0;
        repeat (6) @(negedge clk);
        run(16'h1234, 1, 3, -1, -1, 16'h0, -1, -1, 0);
        for (int r = 0; r < 6; r++) begin
            fa = ($urandom_range(1, 0) == 1) ? int'($urandom_range(LAST, 0)) : -1;
            ta = ($urandom_range(2, 0) == 0) ? int'($urandom_range(LAST, 0)) : -1;
            run(16'($urandom), 1, 3, -1, fa, 16'($urandom_range(16'hFFFF, 1)), ta, -1, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
